// File: rtl/text_buffer_view.sv
// Line-editor text store with edit cursor, cursor-tracking viewport and symbol iterator.
// Latency: cursor moves 1 cycle; insert/delete 1 + shifted-cell count; iterator output 1 cycle after each step.
// Backpressure: one pending command slot (later edges dropped while it is full); iteration pauses while its enable is low.
module text_buffer_view #(
  parameter int SYMBOL_WIDTH  = 7,
  parameter int SYMBOLS_COUNT = 127,
  parameter int VISIBLE_COUNT = 32,
  parameter int LENGTH_WIDTH  = $clog2(SYMBOLS_COUNT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    left,
  input  logic                    right,
  input  logic                    home,
  input  logic                    end_key,
  input  logic                    backspace,
  input  logic                    delete_key,
  input  logic [SYMBOL_WIDTH-1:0] symbol,
  output logic                    input_ready,
  input  logic                    full_iter_en,
  input  logic                    visible_iter_en,
  output logic [SYMBOL_WIDTH-1:0] iter_out,
  output logic                    iter_out_valid,
  output logic                    iter_last,
  output logic                    cursor_left,
  output logic                    cursor_right,
  output logic [LENGTH_WIDTH-1:0] length,
  output logic [LENGTH_WIDTH-1:0] cursor_index,
  output logic [LENGTH_WIDTH-1:0] view_start
);

  localparam int LW = LENGTH_WIDTH;
  localparam logic [LW-1:0] ZERO    = '0;
  localparam logic [LW-1:0] ONE     = LW'(1);
  localparam logic [LW-1:0] SYM_MAX = LW'(SYMBOLS_COUNT);
  localparam logic [LW-1:0] VIS_M1  = LW'(VISIBLE_COUNT - 1);

  typedef enum logic [1:0] {ST_READY, ST_SHIFT_INS, ST_SHIFT_DEL, ST_ITER} state_t;
  typedef enum logic [2:0] {OP_BS, OP_DEL, OP_INS, OP_LEFT, OP_RIGHT, OP_HOME, OP_END} op_t;

  state_t                  state_q, state_d;
  logic                    pend_vld_q, pend_vld_d;
  op_t                     pend_op_q, pend_op_d;
  logic [SYMBOL_WIDTH-1:0] pend_sym_q, pend_sym_d;
  logic [SYMBOL_WIDTH-1:0] ins_sym_q, ins_sym_d;
  logic [5:0]              key_prev_q, key_prev_d;
  logic [SYMBOL_WIDTH-1:0] sym_prev_q, sym_prev_d;
  logic [LW-1:0]           length_q, length_d;
  logic [LW-1:0]           cursor_q, cursor_d;
  logic [LW-1:0]           view_q, view_d;
  logic [LW-1:0]           idx_q, idx_d;
  logic                    del_bs_q, del_bs_d;
  logic                    mode_full_q, mode_full_d;
  logic                    input_ready_q, input_ready_d;
  logic [SYMBOL_WIDTH-1:0] iter_out_q, iter_out_d;
  logic                    iter_vld_q, iter_vld_d;
  logic                    iter_last_q, iter_last_d;
  logic                    cur_l_q, cur_l_d;
  logic                    cur_r_q, cur_r_d;

  // One spare entry keeps every index a viewport pass can reach inside the array.
  logic [SYMBOL_WIDTH-1:0] mem_q [SYMBOLS_COUNT + 1];
  logic                    mem_we;
  logic [LW-1:0]           mem_waddr;
  logic [SYMBOL_WIDTH-1:0] mem_wdata;

  logic [5:0]    key_now, key_edge;
  logic          sym_edge;
  logic          done, do_read;
  logic [LW-1:0] rd_idx, rd_end, view_end;

  assign key_now  = {end_key, home, right, left, delete_key, backspace};
  assign key_edge = key_now & ~key_prev_q;
  assign sym_edge = (symbol != '0) && (sym_prev_q == '0);
  assign view_end = view_q + VIS_M1;

  // Slide the viewport just far enough to contain the new cursor.
  function automatic logic [LW-1:0] view_fit(input logic [LW-1:0] c, input logic [LW-1:0] vs);
    logic [LW:0] vs_hi;
    vs_hi = {1'b0, vs} + {1'b0, VIS_M1};
    if (c < vs)                 return c;
    else if ({1'b0, c} > vs_hi) return c - VIS_M1;
    else                        return vs;
  endfunction

  // Command capture, edit sequencing, iteration stepping and next-state selection.
  always_comb begin
    state_d       = state_q;
    pend_vld_d    = pend_vld_q;
    pend_op_d     = pend_op_q;
    pend_sym_d    = pend_sym_q;
    ins_sym_d     = ins_sym_q;
    key_prev_d    = key_now;
    sym_prev_d    = symbol;
    length_d      = length_q;
    cursor_d      = cursor_q;
    view_d        = view_q;
    idx_d         = idx_q;
    del_bs_d      = del_bs_q;
    mode_full_d   = mode_full_q;
    input_ready_d = 1'b0;
    iter_out_d    = '0;
    iter_vld_d    = 1'b0;
    iter_last_d   = 1'b0;
    cur_l_d       = 1'b0;
    cur_r_d       = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = ZERO;
    mem_wdata     = '0;
    done          = 1'b0;
    do_read       = 1'b0;
    rd_idx        = ZERO;
    rd_end        = ZERO;

    // Only a rising edge loads the single slot; simultaneous edges keep the highest priority one.
    if (!pend_vld_q) begin
      if (key_edge[0])      begin pend_vld_d = 1'b1; pend_op_d = OP_BS;    end
      else if (key_edge[1]) begin pend_vld_d = 1'b1; pend_op_d = OP_DEL;   end
      else if (sym_edge)    begin pend_vld_d = 1'b1; pend_op_d = OP_INS; pend_sym_d = symbol; end
      else if (key_edge[2]) begin pend_vld_d = 1'b1; pend_op_d = OP_LEFT;  end
      else if (key_edge[3]) begin pend_vld_d = 1'b1; pend_op_d = OP_RIGHT; end
      else if (key_edge[4]) begin pend_vld_d = 1'b1; pend_op_d = OP_HOME;  end
      else if (key_edge[5]) begin pend_vld_d = 1'b1; pend_op_d = OP_END;   end
    end

    case (state_q)
      ST_READY: begin
        if (pend_vld_q) begin
          pend_vld_d = 1'b0;
          case (pend_op_q)
            OP_LEFT: begin
              if (cursor_q != ZERO) cursor_d = cursor_q - ONE;
              done = 1'b1;
            end
            OP_RIGHT: begin
              if (cursor_q != length_q) cursor_d = cursor_q + ONE;
              done = 1'b1;
            end
            OP_HOME: begin cursor_d = ZERO;     done = 1'b1; end
            OP_END:  begin cursor_d = length_q; done = 1'b1; end
            OP_INS: begin
              if (length_q == SYM_MAX) begin
                done = 1'b1;
              end else if (cursor_q == length_q) begin
                mem_we    = 1'b1;
                mem_waddr = cursor_q;
                mem_wdata = pend_sym_q;
                length_d  = length_q + ONE;
                cursor_d  = cursor_q + ONE;
                done      = 1'b1;
              end else begin
                // The topmost move happens in the accept cycle so the symbol write
                // lands exactly one cycle after the last move.
                mem_we    = 1'b1;
                mem_waddr = length_q;
                mem_wdata = mem_q[length_q - ONE];
                idx_d     = length_q - ONE;
                ins_sym_d = pend_sym_q;
                state_d   = ST_SHIFT_INS;
              end
            end
            OP_BS: begin
              if (cursor_q == ZERO) begin
                done = 1'b1;
              end else if (cursor_q == length_q) begin
                length_d = length_q - ONE;
                cursor_d = cursor_q - ONE;
                done     = 1'b1;
              end else begin
                idx_d    = cursor_q;
                del_bs_d = 1'b1;
                state_d  = ST_SHIFT_DEL;
              end
            end
            default: begin
              if (cursor_q == length_q) begin
                done = 1'b1;
              end else if (cursor_q + ONE == length_q) begin
                length_d = length_q - ONE;
                done     = 1'b1;
              end else begin
                idx_d    = cursor_q + ONE;
                del_bs_d = 1'b0;
                state_d  = ST_SHIFT_DEL;
              end
            end
          endcase
        end else if (full_iter_en || visible_iter_en) begin
          mode_full_d = full_iter_en;
          do_read     = 1'b1;
          rd_idx      = full_iter_en ? ZERO : view_q;
          rd_end      = full_iter_en ? length_q : view_end;
        end
      end
      ST_SHIFT_INS: begin
        mem_we = 1'b1;
        if (idx_q == cursor_q) begin
          mem_waddr = cursor_q;
          mem_wdata = ins_sym_q;
          length_d  = length_q + ONE;
          cursor_d  = cursor_q + ONE;
          done      = 1'b1;
          state_d   = ST_READY;
        end else begin
          mem_waddr = idx_q;
          mem_wdata = mem_q[idx_q - ONE];
          idx_d     = idx_q - ONE;
        end
      end
      ST_SHIFT_DEL: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q - ONE;
        mem_wdata = mem_q[idx_q];
        if (idx_q == length_q - ONE) begin
          length_d = length_q - ONE;
          if (del_bs_q) cursor_d = cursor_q - ONE;
          done     = 1'b1;
          state_d  = ST_READY;
        end else begin
          idx_d = idx_q + ONE;
        end
      end
      default: begin
        if (mode_full_q ? full_iter_en : visible_iter_en) begin
          do_read = 1'b1;
          rd_idx  = idx_q;
          rd_end  = mode_full_q ? length_q : view_end;
        end
      end
    endcase

    if (do_read) begin
      iter_vld_d = 1'b1;
      iter_out_d = (rd_idx >= length_q) ? '0 : mem_q[rd_idx];
      cur_l_d    = (rd_idx == cursor_q);
      cur_r_d    = (cursor_q != ZERO) && (rd_idx == cursor_q - ONE);
      if (rd_idx == rd_end) begin
        iter_last_d = 1'b1;
        state_d     = ST_READY;
      end else begin
        idx_d   = rd_idx + ONE;
        state_d = ST_ITER;
      end
    end

    if (done) begin
      input_ready_d = 1'b1;
      view_d        = view_fit(cursor_d, view_q);
    end
  end

  // Control and output registers; reset aborts any shift or pass in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_READY;
      pend_vld_q    <= 1'b0;
      pend_op_q     <= OP_BS;
      pend_sym_q    <= '0;
      ins_sym_q     <= '0;
      key_prev_q    <= '0;
      sym_prev_q    <= '0;
      length_q      <= ZERO;
      cursor_q      <= ZERO;
      view_q        <= ZERO;
      idx_q         <= ZERO;
      del_bs_q      <= 1'b0;
      mode_full_q   <= 1'b0;
      input_ready_q <= 1'b0;
      iter_out_q    <= '0;
      iter_vld_q    <= 1'b0;
      iter_last_q   <= 1'b0;
      cur_l_q       <= 1'b0;
      cur_r_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_vld_q    <= pend_vld_d;
      pend_op_q     <= pend_op_d;
      pend_sym_q    <= pend_sym_d;
      ins_sym_q     <= ins_sym_d;
      key_prev_q    <= key_prev_d;
      sym_prev_q    <= sym_prev_d;
      length_q      <= length_d;
      cursor_q      <= cursor_d;
      view_q        <= view_d;
      idx_q         <= idx_d;
      del_bs_q      <= del_bs_d;
      mode_full_q   <= mode_full_d;
      input_ready_q <= input_ready_d;
      iter_out_q    <= iter_out_d;
      iter_vld_q    <= iter_vld_d;
      iter_last_q   <= iter_last_d;
      cur_l_q       <= cur_l_d;
      cur_r_q       <= cur_r_d;
    end
  end

  // Symbol storage: one write per cycle, contents undefined after reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign input_ready    = input_ready_q;
  assign iter_out       = iter_out_q;
  assign iter_out_valid = iter_vld_q;
  assign iter_last      = iter_last_q;
  assign cursor_left    = cur_l_q;
  assign cursor_right   = cur_r_q;
  assign length         = length_q;
  assign cursor_index   = cursor_q;
  assign view_start     = view_q;

endmodule

// File: doc/text_buffer_view.md
Name: text_buffer_view

Overview:
Line-editor text store for the function-entry field, the next generation of the single-line text buffer. It holds up to SYMBOLS_COUNT symbols with an edit cursor, and supports insert, backspace, forward delete, left, right, home and end. It maintains a horizontal viewport of VISIBLE_COUNT cells that always contains the cursor. It streams either the full text or only the visible window to the glyph renderer, with per-symbol cursor flags.

Parameters:
SYMBOL_WIDTH, 7, bits per symbol; symbol code 0 means "no symbol" or "empty cell".
SYMBOLS_COUNT, 127, capacity in symbols.
VISIBLE_COUNT, 32, viewport width in cells; must satisfy 1 <= VISIBLE_COUNT <= SYMBOLS_COUNT+1.

Ports:
clk  input  1  clock; all logic is on posedge.
rst  input  1  reset; synchronous, active-high.
left, right, home, end_key, backspace, delete_key  input  1 each  edit commands (level).
symbol  input  SYMBOL_WIDTH  symbol to insert; nonzero acts as an insert command.
input_ready  output  1  one-cycle pulse when an accepted command has completed.
full_iter_en  input  1  step a full-text iteration.
visible_iter_en  input  1  step a viewport iteration.
iter_out  output  SYMBOL_WIDTH  iterated symbol; 0 for the end slot and for cells past the end.
iter_out_valid  output  1  iter_out and the cursor flags are valid.
iter_last  output  1  marks the final element of the iteration.
cursor_left  output  1  cursor sits immediately left of this cell.
cursor_right  output  1  cursor sits immediately right of this cell.
length  output  clog2(SYMBOLS_COUNT+1)  current symbol count.
cursor_index  output  clog2(SYMBOLS_COUNT+1)  cursor position, 0..length.
view_start  output  clog2(SYMBOLS_COUNT+1)  first visible cell index.

Behaviour:
- Reset: state is READY; length, cursor_index, view_start and pending are 0; all outputs are 0. Storage contents are don't-care. Reset mid-shift or mid-iteration aborts the operation with no input_ready pulse.
- Command capture: the command vector is registered each cycle. A command whose input was 0 last cycle and is 1 now (or symbol changes from 0 to nonzero) loads the single pending register. Only an edge loads it, so a held key yields one action.
- Simultaneous edges: only the highest-priority command is kept. Priority order is backspace, delete_key, symbol, left, right, home, end_key.
- Pending overflow: edges arriving while a command is pending are dropped.
- Execution: a pending command executes only in READY, which takes priority over starting an iteration. Pending clears at acceptance (cycle T).
- Cursor moves:
  - left, right, home and end_key complete at T+1 with input_ready=1.
  - left at 0 and right at length are no-ops that still pulse input_ready.
  - home sets cursor to 0; end_key sets cursor to length.
- Insert:
  - State SHIFT_INS moves cells length-1 down to cursor up by one position, one cell per cycle.
  - It then writes the symbol at cursor; length and cursor each increase by 1.
  - input_ready pulses at T+1+(length-cursor).
  - If length==SYMBOLS_COUNT, the insert is a no-op that pulses at T+1.
- Backspace:
  - If cursor!=0, state SHIFT_DEL moves cells cursor..length-1 down by one position.
  - length and cursor each decrease by 1.
  - input_ready pulses at T+1+(length-cursor).
  - At cursor 0 it is a no-op that pulses at T+1.
- Forward delete:
  - Same shift as backspace, starting at cursor+1; length decreases by 1 and cursor is unchanged.
  - input_ready pulses at T+1+(length-cursor-1).
  - At cursor==length it is a no-op that pulses at T+1.
- Viewport update, in the completion cycle using the new cursor:
  - If cursor < view_start, view_start becomes cursor.
  - If cursor > view_start+VISIBLE_COUNT-1, view_start becomes cursor-VISIBLE_COUNT+1.
  - Otherwise view_start is unchanged.
- Iteration start: in READY with nothing pending, an enable enters ITER. full_iter_en takes priority over visible_iter_en when both are high. The mode is latched for the whole pass.
- Full pass: covers indices 0..length, i.e. length+1 elements.
- Viewport pass: covers view_start..view_start+VISIBLE_COUNT-1.
- Iteration stepping:
  - Each cycle the latched enable is high, one index is read.
  - iter_out_valid=1 on the next cycle. If the enable is low, the iteration pauses and valid=0.
  - iter_out is 0 for index>=length.
  - cursor_left is (index==cursor).
  - cursor_right is (cursor!=0 && index==cursor-1).
  - iter_last accompanies the final element. The block returns to READY in the cycle that output is presented.
- Command edges during ITER are captured into pending and executed after the pass.
- Arithmetic: all index arithmetic is unsigned at LENGTH_WIDTH bits. No wrap-around is reachable, given the checks above.

Test Plan:
- Reset, then full_iter_en held for 1 cycle -> next cycle iter_out=0, valid=1, iter_last=1, cursor_left=1, cursor_right=0.
- Insert 'a','b','c' as edge pulses -> length=3, cursor=3. Then home, then insert 'x' -> input_ready at T+4, full pass yields x,a,b,c,0 with cursor_left on 'a'.
- Text "abc" with cursor 1: delete_key -> "ac", cursor=1; then backspace -> "c", cursor=0; then backspace -> no-op, input_ready still pulses at T+1.
- VISIBLE_COUNT=4: insert 6 symbols -> view_start=3; home -> view_start=0; visible pass yields exactly 4 elements with iter_last on the 4th.
- Fill to 127 symbols, insert again -> length stays 127, input_ready pulses at T+1. Holding a key for 10 cycles -> exactly one action.
- Assert left during a 5-element full pass -> pass completes uninterrupted, then cursor decrements; rst asserted mid-SHIFT_INS -> length=0, no input_ready.
